// File: rtl/elastic_pkg.sv
// Shared parameters and opcode encoding for the elastic PE output half
// (ALU stage, result FIFO and eager fork).
package elastic_pkg;

  localparam int DATA_WIDTH                     = 32;
  localparam int ADDRESS_WIDTH                  = 32;
  localparam int OPERATION_BIT_LENGTH           = 4;
  localparam int NEIGHBOR_PE_NUM                = 4;
  localparam int ELASTIC_BUFFER_SIZE            = 4;
  localparam int ELASTIC_BUFFER_SIZE_BIT_LENGTH = $clog2(ELASTIC_BUFFER_SIZE);

  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_NOP   = 4'd0;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_ADD   = 4'd1;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_SUB   = 4'd2;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_MUL   = 4'd3;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_CONST = 4'd4;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_LOAD  = 4'd5;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_STORE = 4'd6;
  localparam logic [OPERATION_BIT_LENGTH-1:0] OP_ROUTE = 4'd7;

  // NOP, STORE and unassigned opcodes consume the token without producing a result.
  function automatic logic opHasResult(input logic [OPERATION_BIT_LENGTH-1:0] opCode);
    case (opCode)
      OP_ADD, OP_SUB, OP_MUL, OP_CONST, OP_LOAD, OP_ROUTE: opHasResult = 1'b1;
      default:                                             opHasResult = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_fifo.sv
// Circular elastic buffer with occupancy count; depth must be a power of two
// so that the pointers wrap by plain overflow.
module elastic_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_BITS:0]   count_o
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_BITS-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;

  always_comb begin
    wrPtr_d = push_i ? wrPtr_q + DEPTH_BITS'(1) : wrPtr_q;
    rdPtr_d = pop_i  ? rdPtr_q + DEPTH_BITS'(1) : rdPtr_q;
    count_d = count_q;
    if (push_i && !pop_i) count_d = count_q + (DEPTH_BITS+1)'(1);
    if (!push_i && pop_i) count_d = count_q - (DEPTH_BITS+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == (DEPTH_BITS+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/elastic_alu_buffer_fork.sv
// Output half of an elastic CGRA PE: zero-latency ALU, result FIFO and an
// eager fork that broadcasts each buffered result to the masked neighbours.
module elastic_alu_buffer_fork
  import elastic_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DATA_WIDTH-1:0]               input_data_1,
  input  logic [DATA_WIDTH-1:0]               input_data_2,
  input  logic                                valid_input,
  output logic                                stop_input,
  input  logic [OPERATION_BIT_LENGTH-1:0]     op,
  input  logic [DATA_WIDTH-1:0]               const_data,
  output logic [ADDRESS_WIDTH-1:0]            memory_write_address,
  output logic                                memory_write,
  output logic [DATA_WIDTH-1:0]               memory_write_data,
  output logic [ADDRESS_WIDTH-1:0]            memory_read_address,
  input  logic [DATA_WIDTH-1:0]               memory_read_data,
  input  logic [NEIGHBOR_PE_NUM-1:0]          available_output,
  output logic [DATA_WIDTH-1:0]               output_data [NEIGHBOR_PE_NUM],
  output logic [NEIGHBOR_PE_NUM-1:0]          valid_output,
  input  logic [NEIGHBOR_PE_NUM-1:0]          stop_output,
  output logic                                switch_context_alu,
  output logic                                switch_context_fork,
  output logic [ELASTIC_BUFFER_SIZE_BIT_LENGTH:0] DEBUG_data_size
);

  logic [DATA_WIDTH-1:0]      aluResult;
  logic                       hasResult;
  logic                       fire;
  logic                       push;
  logic                       pop;
  logic                       fifoFull;
  logic                       fifoEmpty;
  logic [DATA_WIDTH-1:0]      fifoHead;
  logic                       forkIn;
  logic                       forkAll;
  logic [NEIGHBOR_PE_NUM-1:0] taken;
  logic [NEIGHBOR_PE_NUM-1:0] done_q, done_d;

  always_comb begin
    aluResult = '0;
    hasResult = opHasResult(op);
    case (op)
      OP_ADD:   aluResult = input_data_1 + input_data_2;
      OP_SUB:   aluResult = input_data_1 - input_data_2;
      OP_MUL:   aluResult = input_data_1 * input_data_2;
      OP_CONST: aluResult = const_data;
      OP_LOAD:  aluResult = memory_read_data;
      OP_ROUTE: aluResult = input_data_1;
      default:  aluResult = '0;
    endcase
  end

  // Tokens without a result never need FIFO space, so they are never stalled.
  assign stop_input         = hasResult & fifoFull;
  assign fire               = valid_input & ~stop_input;
  assign push               = fire & hasResult;
  assign switch_context_alu = fire;

  if (ADDRESS_WIDTH > DATA_WIDTH) begin : gZeroExtend
    assign memory_read_address  = {{(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}, input_data_1};
  end else begin : gTruncate
    assign memory_read_address  = input_data_1[ADDRESS_WIDTH-1:0];
  end
  assign memory_write_address = memory_read_address;
  assign memory_write_data    = input_data_2;
  assign memory_write         = fire & (op == OP_STORE);

  elastic_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH      (ELASTIC_BUFFER_SIZE),
    .DEPTH_BITS (ELASTIC_BUFFER_SIZE_BIT_LENGTH)
  ) uFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (aluResult),
    .pop_i   (pop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (DEBUG_data_size)
  );

  // Eager fork: each neighbour takes the head independently; done_q remembers
  // who already has it until every masked neighbour is served.
  assign forkIn              = ~fifoEmpty;
  assign valid_output        = {NEIGHBOR_PE_NUM{forkIn}} & available_output & ~done_q;
  assign taken               = valid_output & ~stop_output;
  assign forkAll             = &(~available_output | done_q | taken);
  assign pop                 = forkIn & forkAll;
  assign switch_context_fork = pop;

  always_comb begin
    done_d = pop ? '0 : (done_q | taken);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= '0;
    else          done_q <= done_d;
  end

  for (genvar k = 0; k < NEIGHBOR_PE_NUM; k++) begin : gForkData
    assign output_data[k] = fifoHead;
  end

endmodule

// File: tb/tb_elastic_alu_buffer_fork.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a queue-based token model of the ALU, buffer and fork.
module tb_elastic_alu_buffer_fork;
  import elastic_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] input_data_1, input_data_2, const_data, memory_read_data;
  logic        valid_input;
  logic [3:0]  op;
  logic [3:0]  available_output, stop_output;
  logic        stop_input, memory_write, switch_context_alu, switch_context_fork;
  logic [31:0] memory_write_address, memory_write_data, memory_read_address;
  logic [31:0] output_data [4];
  logic [3:0]  valid_output;
  logic [2:0]  DEBUG_data_size;

  int checkCount = 0;
  int errorCount = 0;

  // Reference state: buffered result tokens in order, neighbours already served
  // for the head token, and the external memory contents.
  logic [31:0] modelQ [$];
  logic [3:0]  delivered = 4'b0;
  logic [31:0] memModel [logic [31:0]];

  elastic_alu_buffer_fork dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .input_data_1         (input_data_1),
    .input_data_2         (input_data_2),
    .valid_input          (valid_input),
    .stop_input           (stop_input),
    .op                   (op),
    .const_data           (const_data),
    .memory_write_address (memory_write_address),
    .memory_write         (memory_write),
    .memory_write_data    (memory_write_data),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .available_output     (available_output),
    .output_data          (output_data),
    .valid_output         (valid_output),
    .stop_output          (stop_output),
    .switch_context_alu   (switch_context_alu),
    .switch_context_fork  (switch_context_fork),
    .DEBUG_data_size      (DEBUG_data_size)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic makesResult(input logic [3:0] o);
    return ((o >= 4'd1) && (o <= 4'd5)) || (o == 4'd7);
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] rd);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    case (o)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return prod[31:0];
      4'd4:    return c;
      4'd5:    return rd;
      default: return a;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare every output against the model
  // on the falling edge, then advance the model across the rising edge.
  task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [3:0] av, input logic [3:0] st);
    logic [31:0] rd;
    logic        expStop, expFire, nonEmpty, complete;
    logic [3:0]  expValid, taken;
    valid_input      = v;
    op               = o;
    input_data_1     = a;
    input_data_2     = b;
    const_data       = c;
    available_output = av;
    stop_output      = st;
    rd               = memModel.exists(a) ? memModel[a] : 32'h0;
    memory_read_data = rd;
    @(negedge clk);
    expStop  = makesResult(o) && (modelQ.size() == ELASTIC_BUFFER_SIZE);
    expFire  = v && !expStop;
    nonEmpty = (modelQ.size() != 0);
    expValid = nonEmpty ? (av & ~delivered) : 4'b0;
    taken    = expValid & ~st;
    complete = nonEmpty && ((av & ~(delivered | taken)) == 4'b0);
    checkOutput("stop_input", 64'(stop_input), 64'(expStop));
    checkOutput("switch_alu", 64'(switch_context_alu), 64'(expFire));
    checkOutput("mem_write", 64'(memory_write), 64'(expFire && (o == 4'd6)));
    checkOutput("mem_rd_addr", 64'(memory_read_address), 64'(a));
    checkOutput("mem_wr_addr", 64'(memory_write_address), 64'(a));
    checkOutput("mem_wr_data", 64'(memory_write_data), 64'(b));
    checkOutput("valid_output", 64'(valid_output), 64'(expValid));
    checkOutput("switch_fork", 64'(switch_context_fork), 64'(complete));
    checkOutput("data_size", 64'(DEBUG_data_size), 64'(modelQ.size()));
    for (int k = 0; k < 4; k++)
      if (expValid[k]) checkOutput($sformatf("output_data%0d", k), 64'(output_data[k]), 64'(modelQ[0]));
    @(posedge clk);
    if (complete) begin
      void'(modelQ.pop_front());
      delivered = 4'b0;
    end else begin
      delivered = delivered | taken;
    end
    if (expFire && makesResult(o)) modelQ.push_back(aluRef(o, a, b, c, rd));
    if (expFire && (o == 4'd6)) memModel[a] = b;
    #1;
  endtask

  task automatic idleCycles(input int n, input logic [3:0] av, input logic [3:0] st);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, av, st);
  endtask

  initial begin
    logic [3:0]  rOp, rAv, rSt;
    logic [31:0] rA;
    reset_n = 1'b0;
    valid_input = 1'b0; op = 4'd0; input_data_1 = '0; input_data_2 = '0;
    const_data = '0; memory_read_data = '0; available_output = '0; stop_output = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(valid_output), 64'h0);
    checkOutput("reset_size", 64'(DEBUG_data_size), 64'h0);
    checkOutput("reset_stop", 64'(stop_input), 64'h0);
    checkOutput("reset_memwr", 64'(memory_write), 64'h0);
    checkOutput("reset_fork", 64'(switch_context_fork), 64'h0);
    reset_n = 1'b1;

    $display("[TB] ADD 3+4 to neighbour 0");
    applyStimulus(1'b1, OP_ADD, 32'd3, 32'd4, 32'h0, 4'b0001, 4'b0000);
    idleCycles(2, 4'b0001, 4'b0000);

    $display("[TB] backpressure with all neighbours stalled");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, OP_ADD, 32'(i * 10), 32'(i), 32'h0, 4'b1111, 4'b1111);
    checkOutput("bp_size", 64'(DEBUG_data_size), 64'd4);
    idleCycles(6, 4'b1111, 4'b0000);

    $display("[TB] eager fork with neighbour 2 stalled");
    applyStimulus(1'b1, OP_CONST, 32'h1, 32'h2, 32'hA5, 4'b1111, 4'b0100);
    idleCycles(3, 4'b1111, 4'b0100);
    idleCycles(2, 4'b1111, 4'b0000);

    $display("[TB] store then load");
    applyStimulus(1'b1, OP_STORE, 32'h10, 32'h55, 32'h0, 4'b0001, 4'b0000);
    checkOutput("store_no_push", 64'(DEBUG_data_size), 64'd0);
    applyStimulus(1'b1, OP_LOAD, 32'h10, 32'h0, 32'h0, 4'b0001, 4'b0000);
    idleCycles(2, 4'b0001, 4'b0000);

    $display("[TB] empty fork mask drops the token");
    applyStimulus(1'b1, OP_CONST, 32'h0, 32'h0, 32'd9, 4'b0000, 4'b0000);
    idleCycles(2, 4'b0000, 4'b0000);

    $display("[TB] random traffic");
    rAv = 4'b1111;
    for (int i = 0; i < 600; i++) begin
      rOp = 4'($urandom_range(0, 9));
      rA  = ((rOp == OP_LOAD) || (rOp == OP_STORE)) ? 32'($urandom_range(0, 15)) : $urandom;
      if (delivered == 4'b0 && ($urandom_range(0, 3) == 0)) rAv = 4'($urandom);
      rSt = 4'($urandom) & 4'($urandom);
      applyStimulus(($urandom_range(0, 3) != 0), rOp, rA, $urandom, $urandom, rAv, rSt);
    end
    idleCycles(8, rAv, 4'b0000);

    $display("[TB] reset while tokens are buffered");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, OP_ROUTE, 32'(i + 100), 32'h0, 32'h0, 4'b1111, 4'b1111);
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'b1111, 4'b0010);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_size", 64'(DEBUG_data_size), 64'h0);
    checkOutput("midreset_valid", 64'(valid_output), 64'h0);
    modelQ.delete();
    delivered = 4'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, OP_SUB, 32'd5, 32'd9, 32'h0, 4'b1010, 4'b0000);
    idleCycles(3, 4'b1010, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
